// File: rtl/smi_flit_pkg.sv
// Shared SMI flit definitions: end-of-frame control width and the last-slice
// index helper used by the width converters.
package smi_flit_pkg;

    localparam int SMI_EOFC_WIDTH = 8;

    typedef logic [SMI_EOFC_WIDTH-1:0] smiEofc_t;

    // Index of the last slice that carries valid bytes; eofc==0 means a full flit.
    function automatic int smi_last_slice_idx(input smiEofc_t eofc, input int outWidth,
                                              input int ratio);
        int e;
        e = int'(eofc);
        if (e == 0) return ratio - 1;
        return (e + outWidth - 1) / outWidth - 1;
    endfunction

endpackage

// File: rtl/smi_flit_in_reg.sv
// Single-entry input flit register. Clamps eofc to the flit width on load;
// a load on the same edge as a free keeps the entry valid.
module smi_flit_in_reg
    import smi_flit_pkg::*;
#(
    parameter int FlitWidth = 16
) (
    input  logic                   clk,
    input  logic                   arstn,
    input  logic                   load,
    input  logic                   free,
    input  smiEofc_t               inEofc,
    input  logic [FlitWidth*8-1:0] inData,
    output logic                   inValid,
    output smiEofc_t               flitEofc,
    output logic [FlitWidth*8-1:0] flitData
);

    localparam smiEofc_t MaxEofc = SMI_EOFC_WIDTH'(FlitWidth);

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            inValid  <= 1'b0;
            flitEofc <= '0;
            flitData <= '0;
        end else if (load) begin
            inValid  <= 1'b1;
            flitEofc <= (inEofc > MaxEofc) ? MaxEofc : inEofc;
            flitData <= inData;
        end else if (free) begin
            inValid  <= 1'b0;
        end
    end

endmodule

// File: rtl/smi_flit_scale_down.sv
// SMI flit width reducer: splits each input flit into Ratio output slices,
// least significant first, dropping slices past the last valid byte of a frame.
module smi_flit_scale_down
    import smi_flit_pkg::*;
#(
    parameter int FlitWidth = 16,
    parameter int ScaleLog2 = 2
) (
    input  logic                                 clk,
    input  logic                                 arstn,
    input  logic                                 smiInReady,
    input  logic [SMI_EOFC_WIDTH-1:0]            smiInEofc,
    input  logic [FlitWidth*8-1:0]               smiInData,
    output logic                                 smiInStop,
    output logic                                 smiOutReady,
    output logic [SMI_EOFC_WIDTH-1:0]            smiOutEofc,
    output logic [(FlitWidth >> ScaleLog2)*8-1:0] smiOutData,
    input  logic                                 smiOutStop
);

    localparam int OutWidth = FlitWidth >> ScaleLog2;
    localparam int Ratio    = 1 << ScaleLog2;
    localparam int OutBits  = OutWidth * 8;

    logic                   inValid;
    smiEofc_t               flitEofc;
    logic [FlitWidth*8-1:0] flitData;
    logic [ScaleLog2-1:0]   phase;
    logic [ScaleLog2-1:0]   lastIdx;
    logic                   isLast;
    logic                   outLoad;
    logic                   emit;
    logic                   inLoad;
    logic [OutBits-1:0]     sliceData;
    smiEofc_t               sliceEofc;

    assign lastIdx = ScaleLog2'(smi_last_slice_idx(flitEofc, OutWidth, Ratio));
    assign isLast  = (phase == lastIdx);
    assign outLoad = ~smiOutReady | ~smiOutStop;
    assign emit    = inValid & outLoad;

    // Stop is released in the cycle the final slice leaves so the next flit
    // loads on the same edge without a bubble.
    assign smiInStop = inValid & ~(outLoad & isLast);
    assign inLoad    = smiInReady & ~smiInStop;

    assign sliceData = flitData[int'(phase)*OutBits +: OutBits];
    assign sliceEofc = (isLast && flitEofc != '0)
                     ? flitEofc - SMI_EOFC_WIDTH'(int'(phase) * OutWidth)
                     : '0;

    smi_flit_in_reg #(
        .FlitWidth (FlitWidth)
    ) inReg (
        .clk      (clk),
        .arstn    (arstn),
        .load     (inLoad),
        .free     (emit & isLast),
        .inEofc   (smiInEofc),
        .inData   (smiInData),
        .inValid  (inValid),
        .flitEofc (flitEofc),
        .flitData (flitData)
    );

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            smiOutReady <= 1'b0;
            smiOutEofc  <= '0;
            smiOutData  <= '0;
        end else if (outLoad) begin
            if (inValid) begin
                smiOutReady <= 1'b1;
                smiOutEofc  <= sliceEofc;
                smiOutData  <= sliceData;
            end else begin
                smiOutReady <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            phase <= '0;
        end else if (emit) begin
            phase <= isLast ? '0 : phase + ScaleLog2'(1);
        end
    end

endmodule
